mdu_ex_ctrl: RTL and testbench
==============================

# mdu_ex_ctrl

Execute-stage controller sitting between the pipeline's ID/EX register and the multi-cycle MDU. It recognises RV32M instructions in EX and stalls the pipeline. It issues a single start pulse with registered operands held stable, then captures the MDU result in the one cycle it is valid and returns it to the EX/MEM path. It also handles flushes of in-flight operations, rejects MULH-class ops the MDU cannot execute, and short-circuits back-to-back identical operations through a one-entry result cache.

## Interface
- DATA_WIDTH, 32, operand/result width
- MDU_LAT, 33, cycles from the MDU start-sampling edge to the cycle its result output is valid
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX stage holds a valid instruction
- ex_mdu  in  1  EX instruction is OP with funct7=0000001
- ex_funct3  in  3  M-extension funct3
- ex_rs1, ex_rs2  in  DATA_WIDTH  forwarded operand values
- flush  in  1  kill EX instruction (branch/trap)
- stall_req  out  1  hold IF/ID/EX
- res_valid  out  1  result for EX instruction available this cycle
- res_data  out  DATA_WIDTH  result
- res_err  out  1  unsupported funct3 (001/010/011); res_data=0
- mdu_start  out  1  start pulse to MDU
- mdu_op  out  3  funct3 to MDU
- mdu_a, mdu_b  out  DATA_WIDTH  operands to MDU, stable from start through result cycle
- mdu_busy  in  1  MDU busy
- mdu_c  in  DATA_WIDTH  MDU result, valid only in its done cycle

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. Reset → IDLE. Outputs are 0 in reset; cache invalid; cnt=0.
- req = ex_valid & ex_mdu & ~flush. stall_req = ex_valid & ex_mdu & (state≠DONE); stall_req is forced 1 in DRAIN when ex_valid & ex_mdu.
- IDLE, req:
  - funct3∈{001,010,011} → DONE with res_err=1, res_data=0.
  - Else, cache hit (valid & {funct3,rs1,rs2} match) → DONE with the cached data.
  - Else, if mdu_busy=0 → latch op/a/b, go to ISSUE.
  - Else stay in IDLE.
- ISSUE: mdu_start=1 for exactly one cycle; cnt←MDU_LAT; go to WAIT.
- WAIT: cnt decrements each cycle. When cnt==1: res_data←mdu_c, cache←{op,a,b,mdu_c}, valid←1, go to DONE.
- DONE: res_valid=1 for one cycle, then IDLE. res_data/res_err hold until the next DONE.
- flush in ISSUE/WAIT → DRAIN. The MDU cannot be aborted. mdu_a/b/op stay held; cnt keeps counting; mdu_c is discarded and the cache is not updated. At expiry, go to IDLE once mdu_busy=0.
- flush in DONE: res_valid forced 0; go to IDLE.
- flush in IDLE: no issue.
- mdu_a/b/op change only on the IDLE→ISSUE transition.
- Cache stores the final, sign-corrected value. DIV/REM by zero results are cached like any other.

## Timing
- Miss, instruction enters EX at T:
  - stall_req=1 from T through T+MDU_LAT+1.
  - mdu_start at T+1.
  - mdu_c captured at T+1+MDU_LAT.
  - res_valid=1, stall_req=0 at T+MDU_LAT+2, i.e. T+35 with defaults.
- Hit or unsupported op at T: stall_req=1 at T; res_valid at T+1.
- Back-to-back MDU instructions: the second sees IDLE the cycle after DONE. No overlap.
- Reset mid-operation: immediate IDLE and cache invalid. The MDU is reset on the same reset net.

## Test plan
- MUL 7×−3 at T → mdu_start at T+1, res_valid at T+35, res_data=0xFFFFFFEB, stall_req low only at T+35.
- DIVU 100/7 completes, then the identical DIVU follows → second: no mdu_start, res_valid at T+1, res_data=14.
- MULH (funct3=001) → res_valid at T+1, res_err=1, res_data=0, no mdu_start.
- DIV 20/4 with flush at T+10 → DRAIN, no res_valid, cache unchanged. A following REM 20/6 starts only after mdu_busy=0 and returns 2.
- DIV 5/0 → res_data=0xFFFFFFFF. REM −7/0 → 0xFFFFFFF9. A repeat of DIV 5/0 hits the cache.
- rst low during WAIT → all outputs 0 immediately. After release, the same op misses the cache and takes the full latency.

Source files
------------

// File: rtl/mdu_ex_ctrl.sv
// Execute-stage controller for the multi-cycle RV32M unit: stalls EX, issues one start
// pulse with held operands, captures the result, drains flushed ops, and caches the last result.
module mdu_ex_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MDU_LAT    = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mdu,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_WIDTH-1:0] ex_rs1,
  input  logic [DATA_WIDTH-1:0] ex_rs2,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic                  mdu_start,
  output logic [2:0]            mdu_op,
  output logic [DATA_WIDTH-1:0] mdu_a,
  output logic [DATA_WIDTH-1:0] mdu_b,
  input  logic                  mdu_busy,
  input  logic [DATA_WIDTH-1:0] mdu_c
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [2:0]              op_r;
  logic [DATA_WIDTH-1:0]   a_r, b_r;
  logic [DATA_WIDTH-1:0]   res_data_r;
  logic                    res_err_r;
  logic                    cache_vld_r;
  logic [2:0]              cache_op_r;
  logic [DATA_WIDTH-1:0]   cache_a_r, cache_b_r, cache_data_r;

  logic req_s, unsup_s, hit_s;
  logic latch_s, ld_err_s, ld_hit_s, capture_s;

  assign req_s   = ex_valid & ex_mdu & ~flush;
  assign unsup_s = (ex_funct3 == 3'b001) | (ex_funct3 == 3'b010) | (ex_funct3 == 3'b011);
  assign hit_s   = cache_vld_r & (cache_op_r == ex_funct3) &
                   (cache_a_r == ex_rs1) & (cache_b_r == ex_rs2);

  // Next-state and datapath load strobes
  always_comb begin
    state_s   = state_r;
    latch_s   = 1'b0;
    ld_err_s  = 1'b0;
    ld_hit_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (unsup_s) begin
            ld_err_s = 1'b1;
            state_s  = DONE;
          end else if (hit_s) begin
            ld_hit_s = 1'b1;
            state_s  = DONE;
          end else if (!mdu_busy) begin
            latch_s = 1'b1;
            state_s = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (flush) state_s = DRAIN;
        else       state_s = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_s = DRAIN;
        end else if (cnt_r == CNT_W'(1)) begin
          capture_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: state_s = IDLE;
      // The MDU cannot be aborted: wait out its latency and its busy flag.
      DRAIN: begin
        if ((cnt_r <= CNT_W'(1)) && !mdu_busy) state_s = IDLE;
        else                                   state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Latency counter: loaded at issue, runs down through WAIT and DRAIN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ISSUE) begin
      cnt_r <= CNT_W'(MDU_LAT);
    end else if (((state_r == WAIT) || (state_r == DRAIN)) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Operand hold registers feeding the MDU
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r <= 3'b000;
      a_r  <= {DATA_WIDTH{1'b0}};
      b_r  <= {DATA_WIDTH{1'b0}};
    end else if (latch_s) begin
      op_r <= ex_funct3;
      a_r  <= ex_rs1;
      b_r  <= ex_rs2;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
    end
  end

  // Result registers, held until the next completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_r <= {DATA_WIDTH{1'b0}};
      res_err_r  <= 1'b0;
    end else if (ld_err_s) begin
      res_data_r <= {DATA_WIDTH{1'b0}};
      res_err_r  <= 1'b1;
    end else if (ld_hit_s) begin
      res_data_r <= cache_data_r;
      res_err_r  <= 1'b0;
    end else if (capture_s) begin
      res_data_r <= mdu_c;
      res_err_r  <= 1'b0;
    end else begin
      res_data_r <= res_data_r;
      res_err_r  <= res_err_r;
    end
  end

  // One-entry result cache, written only by a completed (unflushed) operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_r  <= 1'b0;
      cache_op_r   <= 3'b000;
      cache_a_r    <= {DATA_WIDTH{1'b0}};
      cache_b_r    <= {DATA_WIDTH{1'b0}};
      cache_data_r <= {DATA_WIDTH{1'b0}};
    end else if (capture_s) begin
      cache_vld_r  <= 1'b1;
      cache_op_r   <= op_r;
      cache_a_r    <= a_r;
      cache_b_r    <= b_r;
      cache_data_r <= mdu_c;
    end else begin
      cache_vld_r  <= cache_vld_r;
      cache_op_r   <= cache_op_r;
      cache_a_r    <= cache_a_r;
      cache_b_r    <= cache_b_r;
      cache_data_r <= cache_data_r;
    end
  end

  // Stall is gated by reset so every output reads zero while reset is held.
  assign stall_req = rst & ex_valid & ex_mdu & (state_r != DONE);
  assign res_valid = (state_r == DONE) & ~flush;
  assign res_data  = res_data_r;
  assign res_err   = res_err_r;
  assign mdu_start = (state_r == ISSUE);
  assign mdu_op    = op_r;
  assign mdu_a     = a_r;
  assign mdu_b     = b_r;

endmodule

// File: tb/tb_mdu_ex_ctrl.sv
// Scoreboard bench for mdu_ex_ctrl with a behavioural MDU that
// presents its result only in the done cycle.
module tb_mdu_ex_ctrl;
  localparam int DW  = 32;
  localparam int LAT = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_mdu, flush;
  logic [2:0]    ex_funct3;
  logic [DW-1:0] ex_rs1, ex_rs2;
  logic          stall_req, res_valid, res_err, mdu_start, mdu_busy;
  logic [DW-1:0] res_data, mdu_a, mdu_b, mdu_c;
  logic [2:0]    mdu_op;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q[$];
  logic [32:0] sb_e;

  int          m_cnt;
  logic [31:0] m_res, m_a, m_b;
  logic [2:0]  m_op;

  mdu_ex_ctrl #(.DATA_WIDTH(DW), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mdu(ex_mdu), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .flush(flush), .stall_req(stall_req),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_busy(mdu_busy), .mdu_c(mdu_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000:  mdu_model = a * b;
      3'b100:  mdu_model = (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
      3'b101:  mdu_model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  mdu_model = (b == 32'd0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
      3'b111:  mdu_model = (b == 32'd0) ? a : a % b;
      default: mdu_model = 32'd0;
    endcase
  endfunction

  // Behavioural MDU on the shared reset net
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0;
    end else if (mdu_start) begin
      m_cnt <= LAT;
      m_res <= mdu_model(mdu_op, mdu_a, mdu_b);
      m_a   <= mdu_a;
      m_b   <= mdu_b;
      m_op  <= mdu_op;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign mdu_busy = (m_cnt != 0);
  assign mdu_c    = (m_cnt == 1) ? m_res : 32'hDEAD_BEEF;

  // Scoreboard and protocol monitor
  always @(negedge clk) begin
    if (rst) begin
      if (mdu_start) chk("start_while_busy", mdu_busy, 1'b0);
      if (m_cnt != 0) chk("operands_held", {mdu_op, mdu_a, mdu_b}, {m_op, m_a, m_b});
      if (sb_q.size() == 0) begin
        chk("spurious_res_valid", res_valid, 1'b0);
      end else if (res_valid) begin
        sb_e = sb_q.pop_front();
        chk("res_data", res_data, sb_e[31:0]);
        chk("res_err", res_err, sb_e[32]);
      end
    end
  end

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat, input int exp_starts);
    int lat, starts, start_at;
    bit got;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mdu = 1'b1; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    sb_q.push_back({exp_e, exp_d});
    lat = 0; starts = 0; start_at = -1; got = 1'b0;
    @(negedge clk);
    chk({tag, "_stall_first"}, stall_req, 1'b1);
    while (1) begin
      if (mdu_start) begin
        starts++;
        if (start_at < 0) start_at = lat;
      end
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      if (lat >= 200) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_completed"}, got, 1'b1);
    if (!got) sb_q.delete();
    if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    if (exp_lat >= 0 && exp_starts == 1) chk({tag, "_start_cycle"}, start_at, 1);
    chk({tag, "_start_count"}, starts, exp_starts);
    chk({tag, "_stall_released"}, stall_req, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mdu = 1'b0;
  endtask

  task automatic flushed_div();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mdu = 1'b1; ex_funct3 = 3'b100; ex_rs1 = 32'd20; ex_rs2 = 32'd4;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; ex_mdu = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stall_req"}, stall_req, 1'b0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_res_err"}, res_err, 1'b0);
    chk({tag, "_mdu_start"}, mdu_start, 1'b0);
    chk({tag, "_mdu_op_a_b"}, {mdu_op, mdu_a, mdu_b}, 67'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    ex_valid = 1'b1; ex_mdu = 1'b1; ex_funct3 = 3'b000; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
    repeat (3) @(posedge clk);
    #1 chk_zero_outputs("reset");
    ex_valid = 1'b0; ex_mdu = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 35, 1);
    run_op("divu_miss", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 35, 1);
    run_op("divu_hit", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1, 0);
    for (int f = 1; f <= 3; f++)
      run_op("unsupported", 3'(f), 32'd9, 32'd3, 32'd0, 1'b1, 1, 0);

    // Flushed op must not disturb the cached DIVU entry
    flushed_div();
    repeat (30) @(posedge clk);
    run_op("divu_hit_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1, 0);

    // REM queued behind a draining DIV waits for the MDU to go idle
    flushed_div();
    run_op("rem_after_drain", 3'b110, 32'd20, 32'd6, 32'd2, 1'b0, -1, 1);
    run_op("div_20_4", 3'b100, 32'd20, 32'd4, 32'd5, 1'b0, 35, 1);

    run_op("div_by_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 35, 1);
    run_op("div_by_zero_hit", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("rem_by_zero", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 35, 1);

    // Reset in the middle of a WAIT, then the cached op must miss
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mdu = 1'b1; ex_funct3 = 3'b101; ex_rs1 = 32'd9; ex_rs2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_zero_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 1'b0; ex_mdu = 1'b0;
    run_op("rem_after_reset", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 35, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
